// File: rtl/watch_pkg.sv
// Shared definitions for the watch timekeeping controller: mode encodings and
// seconds-counter limits.
package watch_pkg;

    // Controller modes; the encoding is also the value driven on mode_o.
    typedef enum logic [1:0] {
        MODE_RUN    = 2'b00,
        MODE_SET_HH = 2'b01,
        MODE_SET_MM = 2'b10
    } mode_e;

    // Last valid seconds value before the minute rolls over.
    localparam logic [5:0] SEC_MAX = 6'd59;

    // Next seconds value with wrap at SEC_MAX; the >= also pulls any out-of-range
    // value straight back to 0 so sec can never run past 59.
    function automatic logic [5:0] sec_next(input logic [5:0] sec);
        return (sec >= SEC_MAX) ? 6'd0 : sec + 6'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, level filter that accepts a
// new level only after it has been seen for DEB_CYC consecutive cycles, and a
// single-cycle press pulse on each accepted released->pressed transition.
module btn_debounce #(
    parameter int unsigned DEB_CYC = 655
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    // Counter only needs to reach DEB_CYC-1; the DEB_CYC-th differing cycle accepts.
    localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    logic          w_differ;
    logic          w_accept;

    // Raw button is asynchronous: bring it into the clock domain first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
        end
    end

    // Accept decision: synchronised level has disagreed long enough.
    always_comb begin
        w_differ = (r_sync2 != r_level);
        w_accept = w_differ && (r_cnt == CNT_LAST);
    end

    // Filter counter, accepted level and registered press pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            // Any cycle of agreement restarts the run, so bounces never accumulate.
            if (!w_differ || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_level <= r_sync2;
            end
            // Only the pressed edge pulses; release is silent and holding never repeats.
            r_press <= w_accept && r_sync2;
        end
    end

    assign press_o = r_press;

endmodule

// File: rtl/watch_time_ctrl.sv
// Watch timekeeping and time-set controller. Divides the crystal to a 1 Hz
// tick, keeps seconds, and issues registered single-cycle increment enables to
// the external minute and hour counters. Mode/inc buttons step the
// RUN -> SET_HH -> SET_MM -> RUN sequence; blink flags blank the digits being set.
module watch_time_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 32768,
    parameter int unsigned DEB_CYC = 655
) (
    input  logic       clk32k_i,
    input  logic       rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       mm_last_i,
    output logic       sec_tick_o,
    output logic       mm_inc_o,
    output logic       hh_inc_o,
    output logic       sec_clr_o,
    output logic [1:0] mode_o,
    output logic       blink_hh_o,
    output logic       blink_mm_o
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

    // Conditioned button presses.
    logic          w_mode_press;
    logic          w_inc_press;

    // State and counters.
    mode_e         r_state;
    mode_e         w_state_d;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_d;
    logic [5:0]    r_sec;
    logic [5:0]    w_sec_d;

    // Registered outputs and their next values.
    logic          r_sec_tick;
    logic          r_mm_inc;
    logic          r_hh_inc;
    logic          r_sec_clr;
    logic          r_blink_hh;
    logic          r_blink_mm;
    logic          w_sec_tick_d;
    logic          w_mm_inc_d;
    logic          w_hh_inc_d;
    logic          w_sec_clr_d;
    logic          w_blink_hh_d;
    logic          w_blink_mm_d;

    logic          w_tick;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_mode (
        .clk_i   (clk32k_i),
        .rst_i   (rst_i),
        .btn_i   (btn_mode_i),
        .press_o (w_mode_press)
    );

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_inc (
        .clk_i   (clk32k_i),
        .rst_i   (rst_i),
        .btn_i   (btn_inc_i),
        .press_o (w_inc_press)
    );

    // One-second tick at the prescaler terminal count.
    always_comb begin
        w_tick = (r_presc == PRE_LAST);
    end

    // Next-state, counter and output-pulse decode for the mode FSM.
    always_comb begin
        w_state_d    = r_state;
        w_presc_d    = w_tick ? '0 : r_presc + 1'b1;
        w_sec_d      = r_sec;
        w_sec_tick_d = 1'b0;
        w_mm_inc_d   = 1'b0;
        w_hh_inc_d   = 1'b0;
        w_sec_clr_d  = 1'b0;

        case (r_state)
            MODE_RUN: begin
                // Inc presses are ignored while running.
                if (w_mode_press) begin
                    w_state_d = MODE_SET_HH;
                end
                if (w_tick) begin
                    w_sec_tick_d = 1'b1;
                    w_sec_d      = sec_next(r_sec);
                    if (r_sec >= SEC_MAX) begin
                        w_mm_inc_d = 1'b1;
                        w_hh_inc_d = mm_last_i;
                    end
                end
            end
            MODE_SET_HH: begin
                // Mode wins over a coincident inc; ticks are ignored, sec frozen.
                if (w_mode_press) begin
                    w_state_d = MODE_SET_MM;
                end else if (w_inc_press) begin
                    w_hh_inc_d = 1'b1;
                end
            end
            MODE_SET_MM: begin
                // Minute setting never carries into hours.
                if (w_mode_press) begin
                    w_state_d   = MODE_RUN;
                    w_sec_d     = 6'd0;
                    w_presc_d   = '0;
                    w_sec_clr_d = 1'b1;
                end else if (w_inc_press) begin
                    w_mm_inc_d = 1'b1;
                end
            end
            default: begin
                w_state_d = MODE_RUN;
            end
        endcase

        // Blink from next-state values so the registered flags line up with
        // the state and prescaler they describe.
        w_blink_hh_d = (w_state_d == MODE_SET_HH) && (w_presc_d >= PRE_HALF);
        w_blink_mm_d = (w_state_d == MODE_SET_MM) && (w_presc_d >= PRE_HALF);
    end

    // FSM state, prescaler and seconds registers.
    always_ff @(posedge clk32k_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= MODE_RUN;
            r_presc <= '0;
            r_sec   <= 6'd0;
        end else begin
            r_state <= w_state_d;
            r_presc <= w_presc_d;
            r_sec   <= w_sec_d;
        end
    end

    // Output registers: every action appears the cycle after its cause.
    always_ff @(posedge clk32k_i or posedge rst_i) begin
        if (rst_i) begin
            r_sec_tick <= 1'b0;
            r_mm_inc   <= 1'b0;
            r_hh_inc   <= 1'b0;
            r_sec_clr  <= 1'b0;
            r_blink_hh <= 1'b0;
            r_blink_mm <= 1'b0;
        end else begin
            r_sec_tick <= w_sec_tick_d;
            r_mm_inc   <= w_mm_inc_d;
            r_hh_inc   <= w_hh_inc_d;
            r_sec_clr  <= w_sec_clr_d;
            r_blink_hh <= w_blink_hh_d;
            r_blink_mm <= w_blink_mm_d;
        end
    end

    assign sec_tick_o = r_sec_tick;
    assign mm_inc_o   = r_mm_inc;
    assign hh_inc_o   = r_hh_inc;
    assign sec_clr_o  = r_sec_clr;
    assign mode_o     = r_state;
    assign blink_hh_o = r_blink_hh;
    assign blink_mm_o = r_blink_mm;

endmodule
